// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a stalled transfer after TIMEOUT_CYCLES.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       write_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic [7:0]       tx_q, tx_d;
  logic             parity_q, parity_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clk_s, data_s, clk_fall, accept, tmo_hit;

  assign clk_s       = clk_sync_q[1];
  assign data_s      = data_sync_q[1];
  assign clk_fall    = clk_prev_q & ~clk_s;
  assign accept      = (state_q == ST_IDLE) && write_data;
  assign clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
  assign data_sync_d = {data_sync_q[0], ps2_data_in};
  assign clk_prev_d  = clk_s;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (accept) begin
      tmo_d = '0;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      tx_q        <= '0;
      parity_q    <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      tx_q        <= tx_d;
      parity_q    <= parity_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Bits advance on device clock falling edges; the device samples on the rising edge.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    parity_d = parity_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (write_data) begin
          tx_d     = tx_data;
          parity_d = ~^tx_data;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (clk_fall) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          if (idx_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          if (!data_s) begin
            state_d = ST_ACK;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      ST_INHIBIT: ps2_clk_oe  = 1'b1;
      ST_REQ:     ps2_data_oe = 1'b1;
      ST_DATA:    ps2_data_oe = ~tx_q[idx_q];
      ST_PARITY:  ps2_data_oe = ~parity_q;
      default:    ps2_data_oe = 1'b0;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 1000;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       write_data;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic       dev_clk, dev_data_low;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int exp_done = 0;
  int exp_err = 0;
  logic pulse_busy = 1'b0;
  logic pulse_oe = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .write_data(write_data),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Open-collector lines with pull-ups: low if either side drives.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as seen by the device: 8 data bits LSB first, odd parity, stop bit.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = ((b >> i) % 2) != 0;
    f[8] = ($countones(b) % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      pulse_busy = busy;
      pulse_oe = ps2_clk_oe | ps2_data_oe;
    end
    if (err) begin
      n_err++;
      pulse_busy = busy;
      pulse_oe = ps2_clk_oe | ps2_data_oe;
    end
    if (done && err) n_both++;
  end

  task automatic xfer(input logic [7:0] b, input bit ack_ok, input int abort_after);
    logic [9:0] got;
    int n, d0, e0;
    d0 = n_done;
    e0 = n_err;
    got = '0;
    @(negedge clk);
    tx_data = b;
    write_data = 1'b1;
    @(negedge clk);
    write_data = 1'b0;
    tx_data = ~b;
    check("busy_after_accept", busy, 1);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < INH + 10) begin
      n++;
      if (n == 1) check("inhibit_data_oe", ps2_data_oe, 0);
      write_data = (n == 5);
      @(negedge clk);
    end
    write_data = 1'b0;
    check("inhibit_cycles", n, INH);
    check("req_data_oe", ps2_data_oe, 1);
    repeat (4) @(negedge clk);
    check("start_bit", ps2_data_in, 0);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack_ok) dev_data_low = 1'b1;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (e <= 10) got[e-1] = ps2_data_in;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
      if (e == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_pulse", done | err, 0);
        return;
      end
    end
    n = 0;
    while (n_done == d0 && n_err == e0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("frame", got, ref_frame(b));
    check("done_count", n_done - d0, ack_ok);
    check("err_count", n_err - e0, !ack_ok);
    check("pulse_busy", pulse_busy, 0);
    check("pulse_oe", pulse_oe, 0);
    if (ack_ok) exp_done++;
    else exp_err++;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    write_data = 1'b0;
    tx_data = '0;
    dev_clk = 1'b1;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    xfer(8'hED, 1'b1, 0);
    xfer(8'h00, 1'b1, 0);
    xfer(8'hFF, 1'b1, 0);
    xfer(8'h01, 1'b1, 0);
    xfer(8'h5A, 1'b0, 0);
    xfer(8'hA5, 1'b1, 4);
    xfer(8'h3C, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      xfer(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 0);
    end

    @(negedge clk);
    tx_data = 8'hF4;
    write_data = 1'b1;
    @(negedge clk);
    write_data = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!err && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", n, TMO);
    check("timeout_busy", busy, 0);
    check("timeout_oe", ps2_clk_oe | ps2_data_oe, 0);
    exp_err++;
`else
    n = 0;
    repeat (TMO + 200) @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_data_oe", ps2_data_oe, 1);
    check("stall_clk_oe", ps2_clk_oe, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("stall_rst_busy", busy, 0);
`endif
    repeat (5) @(negedge clk);
    check("total_done", n_done, exp_done);
    check("total_err", n_err, exp_err);
    check("done_err_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
